matmul_seq: RTL and testbench

Sequencer for the matrix-multiply datapath: loads the input matrix, then runs COLS result columns of MACS multiply-accumulate cycles each. It drives the coefficient ROM address, the input-operand select, the accumulator clear and MAC enable, and writes each finished column result to the result SRAM. It sits between the top-level start/finish handshake and the loader, MAC and result-memory blocks.

---
 rtl/matmul_pkg.sv | 33 +++
 rtl/matmul_addr_gen.sv | 53 +++++
 rtl/matmul_seq.sv | 152 +++++++++++++++
 tb/tb_matmul_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the matrix-multiply sequencer.
//   - state_t: encoding of the six sequencer states
//   - COLS_DEF / MACS_DEF / RAM_AW_DEF: default geometry
//   - col_w / k_w / coef_w: widths of the column counter, the MAC index
//     and the coefficient ROM address
package matmul_pkg;

  localparam int unsigned COLS_DEF   = 4;
  localparam int unsigned MACS_DEF   = 8;
  localparam int unsigned RAM_AW_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic int unsigned col_w(input int unsigned cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

  function automatic int unsigned k_w(input int unsigned macs);
    return (macs > 1) ? $clog2(macs) : 1;
  endfunction

  function automatic int unsigned coef_w(input int unsigned cols, input int unsigned macs);
    return (cols * macs > 1) ? $clog2(cols * macs) : 1;
  endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// matmul_addr_gen: column / MAC-index counters and address generation.
//   clk, rst        clock, asynchronous active-low reset
//   base_ld         capture base_in as the result base address
//   base_in         result base address
//   col_clr/col_inc clear / increment the column counter
//   k_clr/k_inc     clear / increment the MAC index
//   col, k          current counter values
//   coef_addr       col*MACS + k
//   ram_addr        base + col, wrapping modulo 2^RAM_AW
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned MACS   = MACS_DEF,
  parameter int unsigned RAM_AW = RAM_AW_DEF,
  localparam int unsigned COL_W  = col_w(COLS),
  localparam int unsigned K_W    = k_w(MACS),
  localparam int unsigned COEF_W = coef_w(COLS, MACS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_ld,
  input  logic [RAM_AW-1:0] base_in,
  input  logic              col_clr,
  input  logic              col_inc,
  input  logic              k_clr,
  input  logic              k_inc,
  output logic [COL_W-1:0]  col,
  output logic [K_W-1:0]    k,
  output logic [COEF_W-1:0] coef_addr,
  output logic [RAM_AW-1:0] ram_addr
);

  logic [RAM_AW-1:0] base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base <= '0;
      col  <= '0;
      k    <= '0;
    end else begin
      if (base_ld) base <= base_in;
      if (col_clr)      col <= '0;
      else if (col_inc) col <= col + COL_W'(1);
      if (k_clr)        k <= '0;
      else if (k_inc)   k <= k + K_W'(1);
    end
  end

  assign coef_addr = COEF_W'(col) * COEF_W'(MACS) + COEF_W'(k);
  assign ram_addr  = base + RAM_AW'(col);

endmodule

// File: rtl/matmul_seq.sv
// matmul_seq: sequencer for the matrix-multiply datapath. Loads the input
// matrix, then runs COLS columns of MACS MAC cycles and writes each column
// result to the result SRAM.
//   clk, rst      clock, asynchronous active-low reset
//   start         job request (IDLE only); base_addr captured with it
//   load_done     loader finished (LOAD only)
//   ram_busy      result SRAM cannot accept a write this cycle
//   load_en, acc_clr, mac_en, x_sel, coef_addr   datapath controls
//   ram_we_n, ram_addr                           result SRAM write port
//   busy, done    status / one-cycle completion pulse
//   cycle_cnt     busy-cycle counter, present when MATMUL_SEQ_CYCLE_CNT_EN
//                 is defined
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned MACS   = MACS_DEF,
  parameter int unsigned RAM_AW = RAM_AW_DEF,
  localparam int unsigned COL_W  = col_w(COLS),
  localparam int unsigned K_W    = k_w(MACS),
  localparam int unsigned COEF_W = coef_w(COLS, MACS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RAM_AW-1:0] base_addr,
  input  logic              load_done,
  input  logic              ram_busy,
  output logic              load_en,
  output logic              acc_clr,
  output logic              mac_en,
  output logic [K_W-1:0]    x_sel,
  output logic [COEF_W-1:0] coef_addr,
  output logic              ram_we_n,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              busy,
  output logic              done
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  , output logic [15:0]     cycle_cnt
`endif
);

  state_t state, state_nxt;

  logic              base_ld, col_clr, col_inc, k_clr, k_inc;
  logic [COL_W-1:0]  col;
  logic [K_W-1:0]    k;
  logic [COEF_W-1:0] coef_raw;
  logic [RAM_AW-1:0] addr_raw;
  logic              k_last, col_last;

  assign k_last   = (k == K_W'(MACS - 1));
  assign col_last = (col == COL_W'(COLS - 1));

  matmul_addr_gen #(
    .COLS   (COLS),
    .MACS   (MACS),
    .RAM_AW (RAM_AW)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .base_ld   (base_ld),
    .base_in   (base_addr),
    .col_clr   (col_clr),
    .col_inc   (col_inc),
    .k_clr     (k_clr),
    .k_inc     (k_inc),
    .col       (col),
    .k         (k),
    .coef_addr (coef_raw),
    .ram_addr  (addr_raw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (load_done) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_MAC;
      S_MAC:   if (k_last) state_nxt = S_WRITE;
      S_WRITE: if (!ram_busy) state_nxt = col_last ? S_DONE : S_CLEAR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath outputs decode state and counters only; ram_we_n is the single
  // output that also depends on an input (ram_busy) in the same cycle.
  always_comb begin
    load_en   = 1'b0;
    acc_clr   = 1'b0;
    mac_en    = 1'b0;
    x_sel     = '0;
    coef_addr = '0;
    ram_we_n  = 1'b1;
    ram_addr  = '0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    base_ld   = 1'b0;
    col_clr   = 1'b0;
    col_inc   = 1'b0;
    k_clr     = 1'b0;
    k_inc     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          base_ld = 1'b1;
          col_clr = 1'b1;
          k_clr   = 1'b1;
        end
      end
      S_LOAD:  load_en = 1'b1;
      S_CLEAR: begin
        acc_clr = 1'b1;
        k_clr   = 1'b1;
      end
      S_MAC: begin
        mac_en    = 1'b1;
        x_sel     = k;
        coef_addr = coef_raw;
        k_inc     = !k_last;
      end
      S_WRITE: begin
        ram_addr = addr_raw;
        if (!ram_busy) begin
          ram_we_n = 1'b0;
          col_inc  = !col_last;
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (start) cycle_cnt <= '0;
    end else if (cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: self-checking bench for matmul_seq (default geometry).
// Each job is expanded into a per-cycle trace of {inputs, expected outputs}
// from the job description (base, load delay, ram_busy cycles per column),
// then the trace is applied and compared cycle by cycle.
module tb_matmul_seq;

  localparam int unsigned COLS = 4;
  localparam int unsigned MACS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic       load_done = 1'b0;
  logic       ram_busy = 1'b0;
  logic       load_en, acc_clr, mac_en, ram_we_n, busy, done;
  logic [2:0] x_sel;
  logic [4:0] coef_addr;
  logic [7:0] ram_addr;
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  matmul_seq #(
    .COLS   (COLS),
    .MACS   (MACS),
    .RAM_AW (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .load_done (load_done),
    .ram_busy  (ram_busy),
    .load_en   (load_en),
    .acc_clr   (acc_clr),
    .mac_en    (mac_en),
    .x_sel     (x_sel),
    .coef_addr (coef_addr),
    .ram_we_n  (ram_we_n),
    .ram_addr  (ram_addr),
    .busy      (busy),
    .done      (done)
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    , .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [7:0]  base;
    logic        load_done;
    logic        ram_busy;
    logic        load_en;
    logic        acc_clr;
    logic        mac_en;
    logic [2:0]  x_sel;
    logic [4:0]  coef;
    logic        we_n;
    logic [7:0]  ram_addr;
    logic        busy;
    logic        done;
    int unsigned cnt;
  } vec_t;

  vec_t        vq[$];
  int unsigned cnt_m = 0;
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  function automatic vec_t blank();
    vec_t v;
    v.start = 1'b0; v.base = '0; v.load_done = 1'b0; v.ram_busy = 1'b0;
    v.load_en = 1'b0; v.acc_clr = 1'b0; v.mac_en = 1'b0; v.x_sel = '0;
    v.coef = '0; v.we_n = 1'b1; v.ram_addr = '0; v.busy = 1'b0; v.done = 1'b0;
    v.cnt = 0;
    return v;
  endfunction

  // Inputs that must have no effect in the current state get random values.
  function automatic vec_t noisy(input vec_t v, input bit noise, input bit ld_free,
                                 input bit rb_free);
    vec_t r = v;
    r.base = 8'($urandom);
    if (noise) begin
      r.start = 1'($urandom);
      if (ld_free) r.load_done = 1'($urandom);
      if (rb_free) r.ram_busy  = 1'($urandom);
    end
    return r;
  endfunction

  task automatic push(input vec_t v);
    vec_t r = v;
    r.cnt = cnt_m;
    vq.push_back(r);
    if (r.busy && cnt_m < 65535) cnt_m++;
  endtask

  task automatic gen_idle(input int unsigned n, input bit noise);
    vec_t v;
    for (int unsigned i = 0; i < n; i++) begin
      v = blank();
      v.base = 8'($urandom);
      if (noise) begin
        v.load_done = 1'($urandom);
        v.ram_busy  = 1'($urandom);
      end
      push(v);
    end
  endtask

  task automatic gen_job(input logic [7:0] base, input int unsigned ld_delay,
                         input int unsigned bz0, input int unsigned bz1,
                         input int unsigned bz2, input int unsigned bz3,
                         input bit noise);
    vec_t v;
    int unsigned bz[4];
    bz[0] = bz0; bz[1] = bz1; bz[2] = bz2; bz[3] = bz3;
    v = blank();
    v.start = 1'b1;
    v.base  = base;
    if (noise) begin
      v.load_done = 1'($urandom);
      v.ram_busy  = 1'($urandom);
    end
    push(v);
    cnt_m = 0;
    for (int unsigned d = 0; d <= ld_delay; d++) begin
      v = blank();
      v.load_en = 1'b1; v.busy = 1'b1;
      v = noisy(v, noise, 1'b0, 1'b1);
      v.load_done = (d == ld_delay);
      push(v);
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      v = blank();
      v.acc_clr = 1'b1; v.busy = 1'b1;
      push(noisy(v, noise, 1'b1, 1'b1));
      for (int unsigned kk = 0; kk < MACS; kk++) begin
        v = blank();
        v.mac_en = 1'b1; v.busy = 1'b1;
        v.x_sel = 3'(kk);
        v.coef  = 5'(c * MACS + kk);
        push(noisy(v, noise, 1'b1, 1'b1));
      end
      for (int unsigned b = 0; b <= bz[c]; b++) begin
        v = blank();
        v.busy = 1'b1;
        v.ram_addr = 8'(base + c);
        v = noisy(v, noise, 1'b1, 1'b0);
        v.ram_busy = (b < bz[c]);
        v.we_n     = (b < bz[c]);
        push(v);
      end
    end
    v = blank();
    v.done = 1'b1; v.busy = 1'b1;
    push(noisy(v, noise, 1'b1, 1'b1));
  endtask

  task automatic check(input int unsigned idx, input vec_t e);
    bit ok;
    ok = (load_en === e.load_en) && (acc_clr === e.acc_clr) && (mac_en === e.mac_en)
      && (x_sel === e.x_sel) && (coef_addr === e.coef) && (ram_we_n === e.we_n)
      && (ram_addr === e.ram_addr) && (busy === e.busy) && (done === e.done);
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    ok = ok && (cycle_cnt === 16'(e.cnt));
`endif
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL vec%0d: got le=%b ac=%b me=%b x=%0d coef=%0d we_n=%b ra=%h busy=%b done=%b, want le=%b ac=%b me=%b x=%0d coef=%0d we_n=%b ra=%h busy=%b done=%b cnt=%0d",
               idx, load_en, acc_clr, mac_en, x_sel, coef_addr, ram_we_n, ram_addr,
               busy, done, e.load_en, e.acc_clr, e.mac_en, e.x_sel, e.coef, e.we_n,
               e.ram_addr, e.busy, e.done, e.cnt);
    end
  endtask

  task automatic check_reset(input string name);
    bit ok;
    ok = (load_en === 1'b0) && (acc_clr === 1'b0) && (mac_en === 1'b0)
      && (x_sel === 3'd0) && (coef_addr === 5'd0) && (ram_we_n === 1'b1)
      && (ram_addr === 8'h00) && (busy === 1'b0) && (done === 1'b0);
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    ok = ok && (cycle_cnt === 16'd0);
`endif
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got le=%b ac=%b me=%b x=%0d coef=%0d we_n=%b ra=%h busy=%b done=%b, want reset values",
               name, load_en, acc_clr, mac_en, x_sel, coef_addr, ram_we_n, ram_addr,
               busy, done);
    end
  endtask

  task automatic apply_range(input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i < hi; i++) begin
      @(posedge clk);
      #1;
      start     = vq[i].start;
      base_addr = vq[i].base;
      load_done = vq[i].load_done;
      ram_busy  = vq[i].ram_busy;
      #1;
      check(i, vq[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned abort_start, abort_end;

    // Trace table: built entirely before anything is applied.
    gen_idle(2, 1'b1);
    gen_job(8'h10, 0, 0, 0, 0, 0, 1'b0);       // reference timing, done in cycle 42
    gen_idle(3, 1'b1);
    gen_job(8'($urandom), 5, 0, 0, 0, 0, 1'b0); // load_done late by 5 cycles
    gen_idle(1, 1'b0);
    gen_job(8'h10, 0, 0, 3, 0, 0, 1'b0);       // 3 ram_busy cycles, done in cycle 45
    gen_job(8'hFE, 0, 0, 0, 0, 0, 1'b1);       // back-to-back start, address wrap, noise
    gen_idle(2, 1'b1);
    for (int unsigned j = 0; j < 4; j++) begin
      gen_job(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
      gen_idle($urandom_range(0, 2), 1'b1);
    end
    abort_start = vq.size();
    gen_job(8'h40, 0, 0, 0, 0, 0, 1'b0);
    // Keep only up to column-2 MAC k=2: start, LOAD, 2x(CLEAR+8 MAC+WRITE), CLEAR, 3 MAC.
    while (vq.size() > abort_start + 26) void'(vq.pop_back());
    abort_end = vq.size();
    cnt_m = 0;
    gen_idle(2, 1'b1);
    gen_job(8'h80, 1, 0, 1, 0, 0, 1'b1);
    gen_idle(3, 1'b1);

    // Power-on reset
    #3;
    check_reset("por");
    @(negedge clk);
    rst = 1'b1;

    apply_range(0, abort_end);

    // Asynchronous reset in the middle of column-2 MAC
    #1;
    rst = 1'b0;
    start = 1'b0;
    load_done = 1'b0;
    ram_busy = 1'b0;
    #1;
    check_reset("async_rst_mid_job");
    @(posedge clk);
    #1;
    check_reset("rst_held");
    @(negedge clk);
    rst = 1'b1;

    apply_range(abort_end, vq.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
